// File: rtl/rob_nbank.sv
// Multi-bank reorder buffer: rows are dispatched and committed in order, with
// per-entry writeback, tail rollback on branch kill and precise-exception flush.

module rob_nbank_bank #(
    parameter int SIZE      = 8,
    parameter int WIDTH_ROW = 3,
    parameter int WIDTH_REG = 7
) (
    input  logic                 i_clk,
    input  logic                 i_rst_n,
    input  logic                 i_dis_en,
    input  logic [WIDTH_ROW-1:0] i_dis_row,
    input  logic                 i_dis_val,
    input  logic [WIDTH_REG-1:0] i_dis_prd,
    input  logic [SIZE-1:0]      i_clr,
    input  logic [SIZE-1:0]      i_wb_clr,
    input  logic [SIZE-1:0]      i_wb_exc,
    input  logic [WIDTH_ROW-1:0] i_head_row,
    output logic                 o_val,
    output logic                 o_busy,
    output logic                 o_exc,
    output logic [WIDTH_REG-1:0] o_prd
);
    logic [SIZE-1:0]                val_q, busy_q, exc_q;
    logic [SIZE-1:0][WIDTH_REG-1:0] prd_q;

    // A fresh dispatch overrides any writeback or clear aimed at the same row.
    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            val_q  <= '0;
            busy_q <= '0;
            exc_q  <= '0;
            prd_q  <= '0;
        end else begin
            for (int r = 0; r < SIZE; r++) begin
                if (i_dis_en && i_dis_row == WIDTH_ROW'(r)) begin
                    val_q[r]  <= i_dis_val;
                    busy_q[r] <= i_dis_val;
                    exc_q[r]  <= 1'b0;
                    prd_q[r]  <= i_dis_prd;
                end else begin
                    if (i_clr[r])    val_q[r]  <= 1'b0;
                    if (i_wb_clr[r]) busy_q[r] <= 1'b0;
                    if (i_wb_exc[r]) exc_q[r]  <= 1'b1;
                end
            end
        end
    end

    assign o_val  = val_q[i_head_row];
    assign o_busy = busy_q[i_head_row];
    assign o_exc  = exc_q[i_head_row];
    assign o_prd  = prd_q[i_head_row];
endmodule

module rob_nbank #(
    parameter int NBANK     = 4,
    parameter int WIDTH_ROW = 3,
    parameter int WIDTH_REG = 7,
    parameter int NWB       = 4,
    localparam int SIZE     = 1 << WIDTH_ROW,
    localparam int LOG_NB   = $clog2(NBANK),
    localparam int WIDTH_WB = 2 + WIDTH_ROW + LOG_NB
) (
    input  logic                       i_clk,
    input  logic                       i_rst_n,
    input  logic                       i_dis_we,
    input  logic [31:0]                i_dis_pc,
    input  logic [NBANK-1:0]           i_dis_val,
    input  logic [NBANK*WIDTH_REG-1:0] i_dis_prd,
    output logic [WIDTH_ROW-1:0]       o_dis_tag,
    output logic                       o_full,
    output logic                       o_empty,
    input  logic [NWB*WIDTH_WB-1:0]    i_wb,
    input  logic                       i_kill_en,
    input  logic [WIDTH_ROW-1:0]       i_kill_row,
    output logic                       o_com_en,
    output logic [NBANK-1:0]           o_com_val,
    output logic [NBANK*WIDTH_REG-1:0] o_com_prd,
    output logic                       o_exc,
    output logic [31:0]                o_exc_pc
);
    logic [WIDTH_ROW:0]   head_q, head_d, tail_q, tail_d;
    logic [SIZE-1:0][31:0] pc_q;
    logic [WIDTH_ROW-1:0] head_row, kill_off, off;
    logic [WIDTH_ROW:0]   in_flight;

    logic [NBANK-1:0]                h_val, h_busy, h_exc;
    logic [NBANK-1:0][WIDTH_REG-1:0] h_prd;
    logic [NBANK-1:0][SIZE-1:0]      wb_clr, wb_exc;
    logic [SIZE-1:0]                 clr;

    logic row_rdy, any_exc, com_en, flush, kill, dis;

    logic [WIDTH_WB-1:0] pkt;
    int unsigned         pk32, bk, rw;

    assign head_row  = head_q[WIDTH_ROW-1:0];
    assign o_empty   = (head_q == tail_q);
    assign o_full    = (head_row == tail_q[WIDTH_ROW-1:0]) && (head_q[WIDTH_ROW] != tail_q[WIDTH_ROW]);
    assign o_dis_tag = tail_q[WIDTH_ROW-1:0];

    // Head row is ready once every valid lane has completed; empty rows retire at once.
    assign row_rdy = !o_empty && ((h_val & h_busy) == '0);
    assign any_exc = |(h_val & h_exc);
    assign com_en  = row_rdy && !any_exc;
    assign flush   = row_rdy && any_exc;
    assign kill    = i_kill_en && !flush;
    assign dis     = i_dis_we && !o_full && !kill && !flush;

    always_comb begin
        wb_clr = '0;
        wb_exc = '0;
        pkt    = '0;
        pk32   = 0;
        bk     = 0;
        rw     = 0;
        for (int p = 0; p < NWB; p++) begin
            pkt  = i_wb[p*WIDTH_WB +: WIDTH_WB];
            pk32 = 32'(pkt);
            bk   = pk32 % NBANK;
            rw   = (pk32 >> LOG_NB) % SIZE;
            if (pkt[WIDTH_WB-1]) begin
                wb_clr[bk][rw] = 1'b1;
                if (pkt[WIDTH_WB-2]) wb_exc[bk][rw] = 1'b1;
            end
        end
    end

    // Kill drops rows strictly younger than kill_row, measured as distance from head.
    assign kill_off  = i_kill_row - head_row;
    assign in_flight = tail_q - head_q;

    always_comb begin
        clr = '0;
        off = '0;
        for (int r = 0; r < SIZE; r++) begin
            off    = WIDTH_ROW'(r) - head_row;
            clr[r] = flush || (kill && ({1'b0, off} > {1'b0, kill_off}) && ({1'b0, off} < in_flight));
        end
    end

    always_comb begin
        head_d = head_q + (com_en ? 1'b1 : 1'b0);
        tail_d = tail_q;
        if (flush)     tail_d = head_q;
        else if (kill) tail_d = head_q + {1'b0, kill_off} + 1'b1;
        else if (dis)  tail_d = tail_q + 1'b1;
    end

    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            head_q <= '0;
            tail_q <= '0;
            pc_q   <= '0;
        end else begin
            head_q <= head_d;
            tail_q <= tail_d;
            if (dis) pc_q[o_dis_tag] <= i_dis_pc;
        end
    end

    for (genvar b = 0; b < NBANK; b++) begin : g_bank
        rob_nbank_bank #(
            .SIZE      (SIZE),
            .WIDTH_ROW (WIDTH_ROW),
            .WIDTH_REG (WIDTH_REG)
        ) u_bank (
            .i_clk      (i_clk),
            .i_rst_n    (i_rst_n),
            .i_dis_en   (dis),
            .i_dis_row  (o_dis_tag),
            .i_dis_val  (i_dis_val[b]),
            .i_dis_prd  (i_dis_prd[b*WIDTH_REG +: WIDTH_REG]),
            .i_clr      (clr),
            .i_wb_clr   (wb_clr[b]),
            .i_wb_exc   (wb_exc[b]),
            .i_head_row (head_row),
            .o_val      (h_val[b]),
            .o_busy     (h_busy[b]),
            .o_exc      (h_exc[b]),
            .o_prd      (h_prd[b])
        );
        assign o_com_val[b]                         = com_en & h_val[b];
        assign o_com_prd[b*WIDTH_REG +: WIDTH_REG] = com_en ? h_prd[b] : '0;
    end

    assign o_com_en = com_en;
    assign o_exc    = flush;
    assign o_exc_pc = flush ? pc_q[head_row] : 32'h0;
endmodule

// File: tb/tb_rob_nbank.sv
// Randomized + directed bench for rob_nbank: a queue-of-rows reference model
// pushes expected per-cycle outputs into a scoreboard popped by a monitor.

module tb_rob_nbank;
    localparam int NBANK     = 4;
    localparam int WIDTH_ROW = 3;
    localparam int WIDTH_REG = 7;
    localparam int NWB       = 4;
    localparam int SIZE      = 8;
    localparam int LOG_NB    = 2;
    localparam int WIDTH_WB  = 2 + WIDTH_ROW + LOG_NB;
    localparam int PW        = NBANK * WIDTH_REG;

    logic                 i_clk = 1'b0;
    logic                 i_rst_n;
    logic                 i_dis_we;
    logic [31:0]          i_dis_pc;
    logic [NBANK-1:0]     i_dis_val;
    logic [PW-1:0]        i_dis_prd;
    logic [WIDTH_ROW-1:0] o_dis_tag;
    logic                 o_full, o_empty;
    logic [NWB*WIDTH_WB-1:0] i_wb;
    logic                 i_kill_en;
    logic [WIDTH_ROW-1:0] i_kill_row;
    logic                 o_com_en;
    logic [NBANK-1:0]     o_com_val;
    logic [PW-1:0]        o_com_prd;
    logic                 o_exc;
    logic [31:0]          o_exc_pc;

    rob_nbank #(.NBANK(NBANK), .WIDTH_ROW(WIDTH_ROW), .WIDTH_REG(WIDTH_REG), .NWB(NWB)) dut (
        .i_clk(i_clk), .i_rst_n(i_rst_n), .i_dis_we(i_dis_we), .i_dis_pc(i_dis_pc),
        .i_dis_val(i_dis_val), .i_dis_prd(i_dis_prd), .o_dis_tag(o_dis_tag),
        .o_full(o_full), .o_empty(o_empty), .i_wb(i_wb), .i_kill_en(i_kill_en),
        .i_kill_row(i_kill_row), .o_com_en(o_com_en), .o_com_val(o_com_val),
        .o_com_prd(o_com_prd), .o_exc(o_exc), .o_exc_pc(o_exc_pc)
    );

    always #5 i_clk = ~i_clk;

    typedef struct packed {
        logic [NBANK-1:0] val, busy, exc;
        logic [PW-1:0]    prd;
        logic [31:0]      pc;
    } row_t;

    typedef struct packed {
        logic [1:0]           kind;   // 0 idle, 1 commit, 2 exception
        logic [NBANK-1:0]     val;
        logic [PW-1:0]        prd;
        logic [31:0]          pc;
        logic                 full, empty;
        logic [WIDTH_ROW-1:0] tag;
    } exp_t;

    row_t rows[$];
    exp_t sb[$];
    int   head_cnt = 0;
    int   checks = 0, failures = 0;

    function automatic bit head_ready();
        return rows.size() > 0 && ((rows[0].val & rows[0].busy) == '0);
    endfunction

    task automatic push_expect();
        exp_t e;
        e = '0;
        e.full  = (rows.size() == SIZE);
        e.empty = (rows.size() == 0);
        e.tag   = WIDTH_ROW'((head_cnt + rows.size()) % SIZE);
        if (head_ready()) begin
            e.kind = (|(rows[0].val & rows[0].exc)) ? 2'd2 : 2'd1;
            e.val  = rows[0].val;
            e.prd  = rows[0].prd;
            e.pc   = rows[0].pc;
        end
        sb.push_back(e);
    endtask

    // Reference update for one clock edge, using the inputs the bench is driving.
    task automatic model_step();
        bit rdy, ex;
        int n0, old_head, keep, pos;
        logic [WIDTH_WB-1:0] pkt;
        row_t t;
        if (!i_rst_n) begin
            rows.delete();
            head_cnt = 0;
            push_expect();
            return;
        end
        rdy      = head_ready();
        ex       = rdy && (|(rows[0].val & rows[0].exc));
        n0       = rows.size();
        old_head = head_cnt;
        if (ex) begin
            rows.delete();
        end else begin
            for (int p = 0; p < NWB; p++) begin
                pkt = i_wb[p*WIDTH_WB +: WIDTH_WB];
                if (pkt[WIDTH_WB-1]) begin
                    pos = (int'(pkt[LOG_NB +: WIDTH_ROW]) - head_cnt + SIZE) % SIZE;
                    if (pos < rows.size()) begin
                        t = rows[pos];
                        t.busy[pkt[LOG_NB-1:0]] = 1'b0;
                        if (pkt[WIDTH_WB-2]) t.exc[pkt[LOG_NB-1:0]] = 1'b1;
                        rows[pos] = t;
                    end
                end
            end
            if (rdy) begin
                void'(rows.pop_front());
                head_cnt = (head_cnt + 1) % SIZE;
            end
            if (i_kill_en) begin
                keep = (int'(i_kill_row) - old_head + SIZE) % SIZE + 1 - (rdy ? 1 : 0);
                while (rows.size() > keep) void'(rows.pop_back());
            end else if (i_dis_we && n0 < SIZE) begin
                t.val = i_dis_val; t.busy = i_dis_val; t.exc = '0;
                t.prd = i_dis_prd; t.pc = i_dis_pc;
                rows.push_back(t);
            end
        end
        push_expect();
    endtask

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s t=%0t actual=%0h expected=%0h", name, $time, act, exp);
        end
    endtask

    initial begin : monitor
        exp_t e;
        forever begin
            @(negedge i_clk);
            if (sb.size() > 0) begin
                e = sb.pop_front();
                chk("full",    64'(o_full),    64'(e.full));
                chk("empty",   64'(o_empty),   64'(e.empty));
                chk("dis_tag", 64'(o_dis_tag), 64'(e.tag));
                chk("com_en",  64'(o_com_en),  64'(e.kind == 2'd1));
                chk("exc",     64'(o_exc),     64'(e.kind == 2'd2));
                if (e.kind == 2'd1) begin
                    chk("com_val", 64'(o_com_val), 64'(e.val));
                    chk("com_prd", 64'(o_com_prd), 64'(e.prd));
                end
                if (e.kind == 2'd2) chk("exc_pc", 64'(o_exc_pc), 64'(e.pc));
            end
        end
    end

    task automatic tick();
        @(posedge i_clk);
        model_step();
        @(negedge i_clk);
    endtask

    task automatic idle();
        i_dis_we = 0; i_dis_pc = '0; i_dis_val = '0; i_dis_prd = '0;
        i_wb = '0; i_kill_en = 0; i_kill_row = '0;
    endtask

    task automatic dispatch(input logic [31:0] pc, input logic [NBANK-1:0] val, input logic [PW-1:0] prd);
        i_dis_we = 1; i_dis_pc = pc; i_dis_val = val; i_dis_prd = prd;
    endtask

    task automatic wbp(input int p, input logic ex, input int row, input int bank);
        i_wb[p*WIDTH_WB +: WIDTH_WB] = {1'b1, ex, WIDTH_ROW'(row), LOG_NB'(bank)};
    endtask

    task automatic do_reset();
        i_rst_n = 0;
        idle();
        tick();
        i_rst_n = 1;
    endtask

    // Complete every pending lane, NWB per cycle, until the model is empty.
    task automatic drain();
        int p;
        for (int it = 0; it < 64 && rows.size() > 0; it++) begin
            idle();
            p = 0;
            for (int i = 0; i < rows.size(); i++)
                for (int b = 0; b < NBANK; b++)
                    if (p < NWB && rows[i].val[b] && rows[i].busy[b]) begin
                        wbp(p, 1'b0, (head_cnt + i) % SIZE, b);
                        p++;
                    end
            tick();
        end
        idle();
        tick();
    endtask

    task automatic rand_cycle(input int wb_pct);
        int pos;
        idle();
        if ($urandom_range(0, 1) == 1)
            dispatch($urandom, NBANK'($urandom), PW'($urandom));
        for (int p = 0; p < NWB; p++) begin
            if (rows.size() > 0 && $urandom_range(0, 99) < wb_pct) begin
                pos = $urandom_range(0, rows.size() - 1);
                wbp(p, $urandom_range(0, 59) == 0, (head_cnt + pos) % SIZE, $urandom_range(0, NBANK - 1));
            end else if ($urandom_range(0, 19) == 0) begin
                wbp(p, $urandom_range(0, 59) == 0, $urandom_range(0, SIZE - 1), $urandom_range(0, NBANK - 1));
            end
        end
        if (rows.size() > 0 && $urandom_range(0, 39) == 0) begin
            i_kill_en  = 1;
            i_kill_row = WIDTH_ROW'((head_cnt + $urandom_range(0, rows.size() - 1)) % SIZE);
        end
        tick();
    endtask

    initial begin
        i_rst_n = 0;
        idle();
        tick();
        i_rst_n = 1;

        // Sparse row commits lanes 0/2 after two writebacks.
        dispatch(32'h40, 4'b0101, {7'd0, 7'd9, 7'd0, 7'd5});
        tick();
        idle(); wbp(0, 1'b0, 0, 0); wbp(1, 1'b0, 0, 2);
        tick();
        idle();
        tick();
        tick();

        // Fill to full, drop the ninth dispatch, then commit and wrap.
        do_reset();
        for (int i = 0; i < SIZE; i++) begin
            dispatch(32'h200 + 32'(i), 4'b1111, PW'($urandom));
            tick();
        end
        dispatch(32'h2ff, 4'b1111, PW'($urandom));
        tick();
        for (int b = 0; b < NBANK; b++) wbp(b, 1'b0, 0, b);
        tick();
        idle();
        dispatch(32'h300, 4'b0011, PW'($urandom));
        tick();
        tick();
        drain();

        // Rows 0-5 in flight, kill at row 2 with a dispatch in the same cycle.
        do_reset();
        for (int i = 0; i < 6; i++) begin
            dispatch(32'h400 + 32'(i), 4'b1111, PW'($urandom));
            tick();
        end
        dispatch(32'h4ff, 4'b0001, PW'($urandom));
        i_kill_en = 1; i_kill_row = 3'd2;
        tick();
        drain();

        // Exception flush; a kill and dispatch in the flush cycle are ignored.
        do_reset();
        dispatch(32'h100, 4'b0010, PW'($urandom));
        tick();
        idle(); wbp(0, 1'b1, 0, 1);
        tick();
        idle(); i_kill_en = 1; i_kill_row = 3'd0;
        dispatch(32'h500, 4'b0001, PW'($urandom));
        tick();
        idle();
        tick();

        // Two ports on one entry (one with exc) alongside head commit and dispatch.
        do_reset();
        dispatch(32'h600, 4'b0001, PW'($urandom));
        tick();
        dispatch(32'h610, 4'b0001, PW'($urandom));
        wbp(0, 1'b0, 0, 0);
        tick();
        idle();
        wbp(0, 1'b0, 1, 0); wbp(1, 1'b1, 1, 0);
        dispatch(32'h620, 4'b0001, PW'($urandom));
        tick();
        idle();
        tick();
        tick();

        // Randomized phases with different completion pressure.
        do_reset();
        for (int i = 0; i < 1000; i++) rand_cycle(60);
        for (int i = 0; i < 1000; i++) rand_cycle(12);
        do_reset();
        for (int i = 0; i < 1000; i++) rand_cycle(35);
        drain();
        idle();
        tick();
        tick();

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
